uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
8N1 UART receiver, the counterpart of the PMIC's uart_tx. It gives the PMIC a command/diagnostic input path from the host at the same baud rate: 4.16 MHz clock / CLOCKS_PER_BIT 1000 ≈ 4.16 kbaud. Each received byte is held in a one-entry holding register with a valid/ack handshake. Framing errors, overruns and start-bit glitches are detected and flagged.

Parameters:
CLOCKS_PER_BIT, 1000, i_clock cycles per bit period; must be >= 8.
SYNC_STAGES, 2, flip-flop stages in the i_rxSerial synchroniser; must be >= 2.

Ports:
i_clock  in  1  system clock, 4.16 MHz internal oscillator.
i_reset_n  in  1  asynchronous active-low reset.
i_rxSerial  in  1  asynchronous serial line; idles high.
i_rxAck  in  1  consumer acknowledge; clears o_rxValid.
o_rxData  out  8  last good byte received, LSB first on the wire.
o_rxValid  out  1  high while o_rxData holds an unacknowledged byte.
o_rxBusy  out  1  high whenever the FSM is not in IDLE.
o_framingError  out  1  one-cycle pulse: stop bit sampled low.
o_overrun  out  1  one-cycle pulse: new byte completed while o_rxValid was set.

Behaviour:
- Reset is asynchronous, active-low. On assertion: o_rxData=0, o_rxValid=0, o_rxBusy=0, o_framingError=0, o_overrun=0. FSM goes to IDLE. Bit counter, cycle counter and shift register are cleared. Synchroniser flops are set to 1 so the line reads as idle.
- Synchronisation: i_rxSerial passes through SYNC_STAGES flops to give rx_s. All decisions use rx_s only, so there are SYNC_STAGES cycles of input latency.
- Cycle counter: width $clog2(CLOCKS_PER_BIT). It is zeroed on every state entry and counts up each cycle.
- IDLE: when rx_s==0, go to START.
- START: at count == CLOCKS_PER_BIT/2 - 1 (mid start bit):
  - rx_s==0: go to DATA.
  - rx_s==1: glitch. Go to IDLE with no flag.
- DATA: at count == CLOCKS_PER_BIT - 1, shift rx_s into the MSB of the shift register (LSB-first reception) and increment the bit index.
  - After the 8th sample, go to STOP.
  - Samples therefore fall at mid-bit.
- STOP: at count == CLOCKS_PER_BIT - 1, sample rx_s.
  - rx_s==1 and (o_rxValid==0 or i_rxAck==1): load o_rxData from the shift register and set o_rxValid=1 on the next edge. Go to IDLE.
  - rx_s==1 and o_rxValid==1 and i_rxAck==0: pulse o_overrun for 1 cycle. The new byte is discarded; the old o_rxData and o_rxValid are kept. Go to IDLE.
  - rx_s==0: pulse o_framingError for 1 cycle and discard the byte. o_rxValid and o_rxData are unchanged. Go to BREAK.
- BREAK: stay until rx_s==1, then go to IDLE. A held-low line (break) produces exactly one framing-error pulse, not one per frame time.
- Handshake: i_rxAck while o_rxValid==1 clears o_rxValid on the next edge. i_rxAck while o_rxValid==0 is ignored.
- Simultaneous ack and good-byte completion: new data is loaded, o_rxValid stays 1, and no overrun is flagged.
- Latency: o_rxValid rises at most SYNC_STAGES + 1 cycles after the line midpoint of the stop bit.
- Back-to-back frames: returning to IDLE at mid stop bit allows a following start edge to be caught with no dead time.
- o_rxBusy = (state != IDLE). It is a registered decode and must be glitch-free.
- Reset mid-frame: the frame is abandoned, no flags are raised, and reception restarts on the next falling edge after release.
- State encoding: IDLE=0, START=1, DATA=2, STOP=3, BREAK=4 (3 bits).

Decomposition:
- Shared include uart_defs.vh:
  - state encodings (UART_IDLE..UART_BREAK);
  - UART_DATA_BITS=8;
  - default CLOCKS_PER_BIT=1000, so uart_tx and uart_rx share one baud definition.
- One natural sub-module: sync_ff (parameterised SYNC_STAGES, reset value 1). The future I2C handler can reuse it for SDA/SCL.

Test Plan:
- Use CLOCKS_PER_BIT=16. Send 0xA5 8N1, then hold i_rxAck=0 → o_rxValid rises once after the stop midpoint, o_rxData=0xA5, o_framingError=0, o_overrun=0. Then pulse i_rxAck → o_rxValid=0 next cycle.
- Send a 5-cycle low glitch on an idle line → FSM returns to IDLE from START. o_rxValid, o_framingError and o_overrun all stay 0. o_rxBusy is high for ≤ 8+SYNC_STAGES cycles.
- Send 0x3C with the stop bit driven low, then return high after 3 bit times → exactly one o_framingError pulse. o_rxValid stays 0. Send 0x81 afterwards → received correctly.
- Send 0x11 without ack, then 0x22 without ack → one o_overrun pulse at the second stop bit. o_rxData remains 0x11 and o_rxValid stays 1.
- Send 0x11 and leave it unacked. Send 0x22 and assert i_rxAck in exactly the cycle the stop bit is accepted → o_rxData=0x22, o_rxValid=1, no o_overrun.
- Assert i_reset_n=0 during data bit 4 of 0xFF, release, then send 0x5A → after reset all outputs are 0. Only 0x5A is delivered, with no flags. Also loop back from uart_tx at CLOCKS_PER_BIT=1000: 256 bytes 0x00–0xFF all received intact.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: state encodings, frame width and default baud divisor.
// The transmitter and receiver both import this package so they share one baud definition.
package uart_rx_pkg;

  localparam int UART_DATA_BITS      = 8;
  localparam int UART_CLOCKS_PER_BIT = 1000;

  typedef enum logic [2:0] {
    UART_IDLE  = 3'd0,
    UART_START = 3'd1,
    UART_DATA  = 3'd2,
    UART_STOP  = 3'd3,
    UART_BREAK = 3'd4
  } uart_state_t;

endpackage

// File: rtl/uart_rx_sync_ff.sv
// Multi-stage synchroniser for an asynchronous input. Its flops reset to 1 so an idle-high line
// reads as idle straight out of reset. Also intended for the I2C SDA/SCL inputs.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) r_sync <= '1;
    else            r_sync <= {r_sync[STAGES-2:0], i_d};
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-entry holding register and a valid/ack handshake.
// It flags framing errors and overruns, and it ignores start-bit glitches.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = UART_CLOCKS_PER_BIT,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                      i_clock,
  input  logic                      i_reset_n,
  input  logic                      i_rxSerial,
  input  logic                      i_rxAck,
  output logic [UART_DATA_BITS-1:0] o_rxData,
  output logic                      o_rxValid,
  output logic                      o_rxBusy,
  output logic                      o_framingError,
  output logic                      o_overrun
);

  localparam int CW = $clog2(CLOCKS_PER_BIT);
  localparam logic [CW-1:0] LAST_COUNT = CW'(CLOCKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_COUNT = CW'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [2:0]    LAST_BIT   = 3'(UART_DATA_BITS - 1);

  uart_state_t               r_state, w_next;
  logic [CW-1:0]             r_count;
  logic [2:0]                r_bitIdx;
  logic [UART_DATA_BITS-1:0] r_shift, r_data;
  logic                      r_valid, r_busy, r_frameErr, r_overrun;
  logic                      w_rx, w_sample, w_load, w_overrun, w_frameErr;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .i_clock  (i_clock),
    .i_reset_n(i_reset_n),
    .i_d      (i_rxSerial),
    .o_q      (w_rx)
  );

  always_comb begin
    w_next     = r_state;
    w_sample   = 1'b0;
    w_load     = 1'b0;
    w_overrun  = 1'b0;
    w_frameErr = 1'b0;
    case (r_state)
      UART_IDLE:  if (!w_rx) w_next = UART_START;
      UART_START: if (r_count == HALF_COUNT) w_next = w_rx ? UART_IDLE : UART_DATA;
      UART_DATA: begin
        if (r_count == LAST_COUNT) begin
          w_sample = 1'b1;
          if (r_bitIdx == LAST_BIT) w_next = UART_STOP;
        end
      end
      UART_STOP: begin
        if (r_count == LAST_COUNT) begin
          if (!w_rx) begin
            w_frameErr = 1'b1;
            w_next     = UART_BREAK;
          end else begin
            w_next = UART_IDLE;
            // An ack arriving with the new byte frees the holding register, so no overrun
            if (!r_valid || i_rxAck) w_load    = 1'b1;
            else                     w_overrun = 1'b1;
          end
        end
      end
      UART_BREAK: if (w_rx) w_next = UART_IDLE;
      default:    w_next = UART_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= UART_IDLE;
      r_busy  <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != UART_IDLE);
      if (w_next != r_state || w_sample) r_count <= '0;
      else                               r_count <= r_count + 1'b1;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_bitIdx <= '0;
      r_shift  <= '0;
    end else begin
      if (r_state != UART_DATA) r_bitIdx <= '0;
      else if (w_sample)        r_bitIdx <= r_bitIdx + 1'b1;
      if (w_sample) r_shift <= {w_rx, r_shift[UART_DATA_BITS-1:1]};
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_frameErr <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_frameErr <= w_frameErr;
      r_overrun  <= w_overrun;
      if (w_load) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (i_rxAck) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_rxData       = r_data;
  assign o_rxValid      = r_valid;
  assign o_rxBusy       = r_busy;
  assign o_framingError = r_frameErr;
  assign o_overrun      = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit with hand-computed frame timing.
// A monitor counts flag pulses and valid rises so each scenario checks deltas.
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int SYNC = 2;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       rxSerial = 1'b1;
  logic       rxAck = 1'b0;
  logic [7:0] rxData;
  logic       rxValid, rxBusy, framingError, overrun;

  int total = 0;
  int bad = 0;
  int cycleNo = 0;
  int feCount = 0, ovCount = 0, validRises = 0, busyCycles = 0, lastRiseCycle = 0;
  logic prevValid = 1'b0;

  uart_rx #(.CLOCKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
    .i_clock       (clock),
    .i_reset_n     (reset_n),
    .i_rxSerial    (rxSerial),
    .i_rxAck       (rxAck),
    .o_rxData      (rxData),
    .o_rxValid     (rxValid),
    .o_rxBusy      (rxBusy),
    .o_framingError(framingError),
    .o_overrun     (overrun)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycleNo++;

  always @(negedge clock) begin
    if (rxValid && !prevValid) begin
      validRises++;
      lastRiseCycle = cycleNo;
    end
    prevValid = rxValid;
    if (framingError) feCount++;
    if (overrun) ovCount++;
    if (rxBusy) busyCycles++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulseAck();
    rxAck = 1'b1;
    tick(1);
    rxAck = 1'b0;
  endtask

  // Drives one 8N1 frame; optionally raises ack or reset at a given cycle offset of the frame
  task automatic applyStimulus(input logic [7:0] data, input logic stopLevel, input int ackCycle,
                               input int resetCycle, output int startCycle);
    startCycle = cycleNo;
    for (int c = 0; c < 10 * CPB; c++) begin
      int b;
      b = c / CPB;
      if (b == 0)      rxSerial = 1'b0;
      else if (b <= 8) rxSerial = data[b-1];
      else             rxSerial = stopLevel;
      if (ackCycle >= 0) rxAck = (c == ackCycle);
      if (resetCycle >= 0) begin
        if (c == resetCycle) reset_n = 1'b0;
        if (c == resetCycle + 1) begin
          checkOutput("rstMidData", {24'd0, rxData}, 32'h0);
          checkOutput("rstMidValid", {31'd0, rxValid}, 32'h0);
          checkOutput("rstMidBusy", {31'd0, rxBusy}, 32'h0);
          checkOutput("rstMidFlags", {30'd0, framingError, overrun}, 32'h0);
        end
        if (c == resetCycle + 3) reset_n = 1'b1;
      end
      tick(1);
    end
    if (ackCycle >= 0) rxAck = 1'b0;
  endtask

  initial begin
    int t0, fe0, ov0, vr0, bz0;
    logic [7:0] loopBytes [8];
    loopBytes = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h01, 8'h80, 8'h7E, 8'hC3};

    tick(3);
    checkOutput("rstData", {24'd0, rxData}, 32'h0);
    checkOutput("rstValid", {31'd0, rxValid}, 32'h0);
    checkOutput("rstBusy", {31'd0, rxBusy}, 32'h0);
    checkOutput("rstFlags", {30'd0, framingError, overrun}, 32'h0);
    reset_n = 1'b1;
    tick(5);

    // Good byte: valid rises 155 cycles after the start edge (stop midpoint + SYNC + 1)
    fe0 = feCount; ov0 = ovCount; vr0 = validRises;
    applyStimulus(8'hA5, 1'b1, -1, -1, t0);
    tick(4);
    checkOutput("a5Valid", {31'd0, rxValid}, 32'h1);
    checkOutput("a5Data", {24'd0, rxData}, 32'hA5);
    checkOutput("a5Rises", validRises - vr0, 1);
    checkOutput("a5Latency", lastRiseCycle - t0, 155);
    checkOutput("a5Flags", (feCount - fe0) + (ovCount - ov0), 0);
    pulseAck();
    checkOutput("a5AckClr", {31'd0, rxValid}, 32'h0);

    // Five-cycle low glitch: START gives up at mid start bit
    fe0 = feCount; ov0 = ovCount; vr0 = validRises; bz0 = busyCycles;
    rxSerial = 1'b0;
    tick(5);
    rxSerial = 1'b1;
    tick(30);
    checkOutput("glitchBusyMax", (busyCycles - bz0) <= 8 + SYNC, 1);
    checkOutput("glitchBusySeen", (busyCycles - bz0) > 0, 1);
    checkOutput("glitchBusyNow", {31'd0, rxBusy}, 32'h0);
    checkOutput("glitchEvents", (feCount - fe0) + (ovCount - ov0) + (validRises - vr0), 0);

    // Framing error followed by a 3-bit-time low line: exactly one pulse
    fe0 = feCount; vr0 = validRises;
    applyStimulus(8'h3C, 1'b0, -1, -1, t0);
    tick(2 * CPB);
    rxSerial = 1'b1;
    tick(20);
    checkOutput("feCount", feCount - fe0, 1);
    checkOutput("feValid", {31'd0, rxValid}, 32'h0);
    checkOutput("feBusy", {31'd0, rxBusy}, 32'h0);
    applyStimulus(8'h81, 1'b1, -1, -1, t0);
    tick(4);
    checkOutput("x81Valid", {31'd0, rxValid}, 32'h1);
    checkOutput("x81Data", {24'd0, rxData}, 32'h81);
    checkOutput("x81Rises", validRises - vr0, 1);
    pulseAck();

    // Back-to-back unacked bytes: overrun keeps the first byte
    ov0 = ovCount;
    applyStimulus(8'h11, 1'b1, -1, -1, t0);
    applyStimulus(8'h22, 1'b1, -1, -1, t0);
    tick(4);
    checkOutput("ovCount", ovCount - ov0, 1);
    checkOutput("ovData", {24'd0, rxData}, 32'h11);
    checkOutput("ovValid", {31'd0, rxValid}, 32'h1);

    // Ack in the exact load cycle: new byte replaces the old one, no overrun
    ov0 = ovCount;
    applyStimulus(8'h22, 1'b1, 154, -1, t0);
    tick(4);
    checkOutput("ackLoadData", {24'd0, rxData}, 32'h22);
    checkOutput("ackLoadValid", {31'd0, rxValid}, 32'h1);
    checkOutput("ackLoadOv", ovCount - ov0, 0);
    pulseAck();
    checkOutput("ackLoadClr", {31'd0, rxValid}, 32'h0);

    // Reset during data bit 4 of 0xFF, then a clean 0x5A
    fe0 = feCount; ov0 = ovCount; vr0 = validRises;
    applyStimulus(8'hFF, 1'b1, -1, 4 * CPB + CPB + 8, t0);
    tick(20);
    checkOutput("postRstBusy", {31'd0, rxBusy}, 32'h0);
    checkOutput("postRstValid", {31'd0, rxValid}, 32'h0);
    applyStimulus(8'h5A, 1'b1, -1, -1, t0);
    tick(4);
    checkOutput("x5aData", {24'd0, rxData}, 32'h5A);
    checkOutput("x5aValid", {31'd0, rxValid}, 32'h1);
    checkOutput("x5aRises", validRises - vr0, 1);
    checkOutput("x5aFlags", (feCount - fe0) + (ovCount - ov0), 0);
    pulseAck();

    // Short loop of assorted bytes, each acknowledged immediately
    for (int i = 0; i < 8; i++) begin
      applyStimulus(loopBytes[i], 1'b1, -1, -1, t0);
      tick(4);
      checkOutput($sformatf("loop%0d", i), {23'd0, rxValid, rxData}, {23'd0, 1'b1, loopBytes[i]});
      pulseAck();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
